// File: rtl/alu_div_seq_pkg.sv
// Shared constants for the division sequencer: ALU opcodes it drives and the datapath width.
package alu_div_seq_pkg;
    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_BGEU = 4'd9;
endpackage

// File: rtl/alu_div_seq.sv
// Radix-2 restoring divider for div.w[u]/mod.w[u] that borrows the shared ALU one
// operation per cycle; fixed 68-cycle latency from accepted start to the done pulse.
module alu_div_seq
    import alu_div_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            op_signed,
    input  logic            op_rem,
    input  logic [XLEN-1:0] src_n,
    input  logic [XLEN-1:0] src_d,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_c,
    input  logic            alu_f
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG_N = 3'd1,
        S_NEG_D = 3'd2,
        S_CMP   = 3'd3,
        S_SUB   = 3'd4,
        S_FIX   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] rem, quo, dvs;
    logic            ge, neg_q, neg_r, sel_rem, sgn;
    logic [4:0]      cnt;
    logic [XLEN-1:0] sh, fix_a;

    // Partial remainder shifted left with the next dividend bit; rem[31] is the lost 33rd bit.
    assign sh    = {rem[XLEN-2:0], quo[XLEN-1]};
    assign fix_a = sel_rem ? rem : quo;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_NEG_N;
            S_NEG_N: state_nxt = S_NEG_D;
            S_NEG_D: state_nxt = S_CMP;
            S_CMP:   state_nxt = S_SUB;
            S_SUB:   state_nxt = (cnt == 5'd31) ? S_FIX : S_CMP;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
        case (state)
            S_NEG_N: begin alu_a = quo;   alu_op = OP_SUB;  end
            S_NEG_D: begin alu_a = dvs;   alu_op = OP_SUB;  end
            S_CMP:   begin alu_a = dvs;   alu_b = sh; alu_op = OP_BGEU; end
            S_SUB:   begin alu_a = dvs;   alu_b = sh; alu_op = OP_SUB;  end
            S_FIX:   begin alu_a = fix_a; alu_op = OP_SUB;  end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Operands park in quo/dvs until the NEG steps replace them with magnitudes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            ge      <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            sgn     <= 1'b0;
            cnt     <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    quo     <= src_n;
                    dvs     <= src_d;
                    sgn     <= op_signed;
                    sel_rem <= op_rem;
                    neg_q   <= op_signed & (src_n[XLEN-1] ^ src_d[XLEN-1]) & (src_d != '0);
                    neg_r   <= op_signed & src_n[XLEN-1];
                end
                S_NEG_N: begin
                    quo <= (sgn & quo[XLEN-1]) ? alu_c : quo;
                    rem <= '0;
                end
                S_NEG_D: begin
                    dvs <= (sgn & dvs[XLEN-1]) ? alu_c : dvs;
                    cnt <= '0;
                end
                S_CMP: ge <= alu_f | rem[XLEN-1];
                S_SUB: begin
                    rem <= ge ? alu_c : sh;
                    quo <= {quo[XLEN-2:0], ge};
                    cnt <= cnt + 5'd1;
                end
                S_FIX: result <= (sel_rem ? neg_r : neg_q) ? alu_c : fix_a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: models the shared ALU, drives directed and random divisions,
// and compares latency and result against an arithmetic reference.
module tb_alu_div_seq;
    import alu_div_seq_pkg::*;

    // Handshake: start is a one-cycle request honoured only in IDLE; done pulses once with
    // result valid, exactly 68 cycles after the accepting edge.

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_signed = 1'b0;
    logic        op_rem = 1'b0;
    logic [31:0] src_n = '0;
    logic [31:0] src_d = '0;
    logic        busy, done;
    logic [31:0] result, alu_a, alu_b, alu_c;
    logic [3:0]  alu_op;
    logic        alu_f;

    int n_checks = 0;
    int n_fail   = 0;

    alu_div_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_signed(op_signed), .op_rem(op_rem),
        .src_n(src_n), .src_d(src_d), .busy(busy), .done(done), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_f(alu_f)
    );

    always #5 clk = ~clk;

    // Shared ALU behaviour the sequencer relies on.
    always_comb begin
        alu_c = '0;
        alu_f = 1'b0;
        case (alu_op)
            OP_ADD:  alu_c = alu_a + alu_b;
            OP_SUB:  alu_c = alu_b - alu_a;
            OP_BGEU: alu_f = (alu_b >= alu_a);
            default: ;
        endcase
    end

    function automatic logic [31:0] ref_div(input logic sg, input logic r,
                                            input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q, m;
        longint sn, sd;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        if (d == 32'd0) begin
            q = 32'hFFFF_FFFF;
            m = n;
        end else if (!sg) begin
            q = n / d;
            m = n % d;
        end else if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            m = 32'd0;
        end else begin
            q = 32'(sn / sd);
            m = 32'(sn % sd);
        end
        return r ? m : q;
    endfunction

    task automatic drive_op(input logic sg, input logic r, input logic [31:0] n,
                            input logic [31:0] d);
        op_signed = sg;
        op_rem    = r;
        src_n     = n;
        src_d     = d;
        start     = 1'b1;
    endtask

    // Accepts an operation in the current cycle and returns its result and latency (-1 on timeout).
    task automatic run_op(input logic sg, input logic r, input logic [31:0] n,
                          input logic [31:0] d, output logic [31:0] res, output int lat);
        drive_op(sg, r, n, d);
        @(posedge clk); #1;
        start = 1'b0;
        src_n = $urandom;
        src_d = $urandom;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (alu_op !== OP_ADD || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            n_fail++; $display("FAIL reset_alu got op=%h a=%h b=%h want op=%h a=0 b=0", alu_op, alu_a, alu_b, OP_ADD);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] tn [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000};
        logic [31:0] td [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'h8000_0001,
                                32'h8000_0001, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic        ts [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        tr [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] te [9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                                32'h7FFF_FFFE, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 9; i++) begin
            run_op(ts[i], tr[i], tn[i], td[i], res, lat);
            n_checks++; if (lat !== 68) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want 68", i, lat); end
            n_checks++; if (res !== te[i]) begin n_fail++; $display("FAIL directed_result[%0d] got %h want %h", i, res, te[i]); end
            @(posedge clk); #1;
        end
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL overflow_rem got %h want 0", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        logic [31:0] exp_a, exp_d, res;
        int cyc, lat;
        exp_a = ref_div(1'b0, 1'b0, 32'd1000, 32'd3);
        drive_op(1'b0, 1'b0, 32'd1000, 32'd3);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_cycle1 got %b want 1", busy); end
        while (cyc < 68) begin
            if (cyc == 10) drive_op(1'b1, 1'b1, 32'hDEAD_BEEF, 32'd17);
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (cyc < 68 && done !== 1'b0) begin
                n_checks++; n_fail++; $display("FAIL early_done cycle %0d got 1 want 0", cyc);
            end
        end
        n_checks++; if (done !== 1'b1)  begin n_fail++; $display("FAIL ignore_done68 got %b want 1", done); end
        n_checks++; if (result !== exp_a) begin n_fail++; $display("FAIL ignore_result got %h want %h", result, exp_a); end
        drive_op(1'b0, 1'b1, 32'd77, 32'd5);
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL ignore_cycle69 got busy=%b done=%b want 0 0", busy, done);
        end
        n_checks++; if (result !== exp_a) begin n_fail++; $display("FAIL result_hold got %h want %h", result, exp_a); end
        exp_d = ref_div(1'b1, 1'b0, 32'hFFFF_FF00, 32'd9);
        run_op(1'b1, 1'b0, 32'hFFFF_FF00, 32'd9, res, lat);
        n_checks++; if (lat !== 68)   begin n_fail++; $display("FAIL accept69_latency got %0d want 68", lat); end
        n_checks++; if (res !== exp_d) begin n_fail++; $display("FAIL accept69_result got %h want %h", res, exp_d); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_r, res;
        int cyc, lat;
        drive_op(1'b0, 1'b0, 32'd123456, 32'd789);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL midrst_result got %h want 0", result); end
        n_checks++; if (alu_op !== OP_ADD) begin n_fail++; $display("FAIL midrst_aluop got %h want %h", alu_op, OP_ADD); end
        exp_r = ref_div(1'b1, 1'b1, 32'hFFFF_F000, 32'd77);
        run_op(1'b1, 1'b1, 32'hFFFF_F000, 32'd77, res, lat);
        n_checks++; if (lat !== 68)   begin n_fail++; $display("FAIL postrst_latency got %0d want 68", lat); end
        n_checks++; if (res !== exp_r) begin n_fail++; $display("FAIL postrst_result got %h want %h", res, exp_r); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] n, d, exp_r, res;
        logic sg, r;
        int lat;
        for (int i = 0; i < 24; i++) begin
            n  = $urandom;
            sg = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       d = 32'($urandom_range(0, 15));
                1:       d = -32'($urandom_range(1, 15));
                2:       d = $urandom >> $urandom_range(0, 31);
                default: d = $urandom;
            endcase
            exp_r = ref_div(sg, r, n, d);
            run_op(sg, r, n, d, res, lat);
            n_checks++; if (lat !== 68) begin n_fail++; $display("FAIL random_latency[%0d] got %0d want 68", i, lat); end
            n_checks++; if (res !== exp_r) begin
                n_fail++; $display("FAIL random_result[%0d] s=%b r=%b n=%h d=%h got %h want %h", i, sg, r, n, d, res, exp_r);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
